shift_register_ctrl: RTL

//  Parametrised universal register for the sum-and-shift datapath.
//  - Holds a WIDTH-bit word.
//  - Runs one command per start: hold, parallel load, or a multi-cycle shift/rotate of N positions.
//  - Shifts move one bit per clock, with serial in and serial out.
//  - busy/done handshake lets the multiplier control FSM sequence it without counting cycles.

---
 rtl/shift_register_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/shift_register_ctrl.sv
// Universal WIDTH-bit register: hold, parallel load and multi-cycle shift/rotate with a busy/done handshake.
// Optional feature: define SHREG_ROTATE_EN to enable ROL (101) / ROR (110); otherwise those codes act as HOLD.
module shift_register_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_SAR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       op_q;
    logic [2:0]       op_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             sout_nxt;
    logic [WIDTH-1:0] shift_data;
    logic             shift_bit;

    // Codes that run the multi-cycle shift engine; everything else completes immediately.
    function automatic logic is_shift_op(input logic [2:0] code);
        logic r;
        r = 1'b0;
        case (code)
            OP_SHL, OP_SHR, OP_SAR: r = 1'b1;
`ifdef SHREG_ROTATE_EN
            OP_ROL, OP_ROR:         r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // One-bit step of the latched command.
    always_comb begin
        shift_data = out;
        shift_bit  = serial_out;
        case (op_q)
            OP_SHL: begin
                shift_data = {out[WIDTH-2:0], serial_in};
                shift_bit  = out[WIDTH-1];
            end
            OP_SHR: begin
                shift_data = {serial_in, out[WIDTH-1:1]};
                shift_bit  = out[0];
            end
            OP_SAR: begin
                shift_data = {out[WIDTH-1], out[WIDTH-1:1]};
                shift_bit  = out[0];
            end
`ifdef SHREG_ROTATE_EN
            OP_ROL: begin
                shift_data = {out[WIDTH-2:0], out[WIDTH-1]};
                shift_bit  = out[WIDTH-1];
            end
            OP_ROR: begin
                shift_data = {out[0], out[WIDTH-1:1]};
                shift_bit  = out[0];
            end
`endif
            default: begin
                shift_data = out;
                shift_bit  = serial_out;
            end
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        data_nxt  = out;
        sout_nxt  = serial_out;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift_op(op) && (amount != '0)) begin
                        op_nxt    = op;
                        cnt_nxt   = amount;
                        state_nxt = ST_RUN;
                    end else begin
                        if (op == OP_LOAD) begin
                            data_nxt = in;
                        end
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                data_nxt = shift_data;
                sout_nxt = shift_bit;
                cnt_nxt  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset || !clear) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_q       <= OP_HOLD;
            out        <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            op_q       <= op_nxt;
            out        <= data_nxt;
            serial_out <= sout_nxt;
            busy       <= (state_nxt != ST_IDLE);
            done       <= (state_nxt == ST_DONE);
        end
    end

endmodule
